// File: rtl/banked_register_file_tracked.sv
// banked_register_file_tracked
//
// Multi-bank physical register file with per-entry inflight scoreboard and owner-group
// table. Each write-back port owns one storage bank; a reader picks the bank recorded in
// the owner-group table for that entry. Operand reads are registered (1-cycle latency),
// and an operand captured while its producer is still inflight is completed later by
// snooping the owning write-back port, without a new read request.
//
// After reset (or a flush via init_req) an initialisation sweep clears one entry per cycle
// in every bank; init_done rises once the sweep has covered all DEPTH entries.
//
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   init_req          flush pulse (RUN only), restarts the init sweep
//   init_done         high while in RUN
//   alloc_*           mark an entry inflight and record its producing write port
//   wb_*              per-port write-back (valid, address, data), packed port-major
//   rd_req, rd_addr   capture new operand addresses (packed port-major)
//   rd_data           registered operand data (packed port-major)
//   rd_pending        per read port: operand still awaiting its write-back

module banked_register_file_tracked #(
    parameter int unsigned WRITE_PORTS = 2,
    parameter int unsigned READ_PORTS  = 2,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH       = 64,
    parameter bit          ZERO_REG    = 1'b1,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned GW = (WRITE_PORTS > 1) ? $clog2(WRITE_PORTS) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             init_req,
    output logic                             init_done,
    input  logic                             alloc_valid,
    input  logic [AW-1:0]                    alloc_addr,
    input  logic [GW-1:0]                    alloc_group,
    input  logic [WRITE_PORTS-1:0]           wb_valid,
    input  logic [WRITE_PORTS*AW-1:0]        wb_addr,
    input  logic [WRITE_PORTS*DATA_WIDTH-1:0] wb_data,
    input  logic                             rd_req,
    input  logic [READ_PORTS*AW-1:0]         rd_addr,
    output logic [READ_PORTS*DATA_WIDTH-1:0] rd_data,
    output logic [READ_PORTS-1:0]            rd_pending
);

    typedef enum logic {StInit, StRun} state_e;

    state_e                state_q, state_d;
    logic [AW-1:0]         cnt_q, cnt_d;

    logic [DATA_WIDTH-1:0] bank_q [WRITE_PORTS][DEPTH];
    logic [DATA_WIDTH-1:0] bank_d [WRITE_PORTS][DEPTH];
    logic [DEPTH-1:0]      inflight_q, inflight_d;
    logic [GW-1:0]         group_q [DEPTH];
    logic [GW-1:0]         group_d [DEPTH];

    logic [DATA_WIDTH-1:0] rd_data_q [READ_PORTS];
    logic [DATA_WIDTH-1:0] rd_data_d [READ_PORTS];
    logic [READ_PORTS-1:0] rd_pending_q, rd_pending_d;
    logic [AW-1:0]         held_addr_q [READ_PORTS];
    logic [AW-1:0]         held_addr_d [READ_PORTS];
    logic [GW-1:0]         held_group_q [READ_PORTS];
    logic [GW-1:0]         held_group_d [READ_PORTS];

    // Unpacked views of the packed port buses.
    logic [AW-1:0]         wb_addr_a [WRITE_PORTS];
    logic [DATA_WIDTH-1:0] wb_data_a [WRITE_PORTS];
    logic [WRITE_PORTS-1:0] wb_zero;

    logic [AW-1:0]         rd_addr_a [READ_PORTS];
    logic [GW-1:0]         rd_grp [READ_PORTS];
    logic [DATA_WIDTH-1:0] rd_bank [READ_PORTS];
    logic [READ_PORTS-1:0] rd_hit;
    logic [READ_PORTS-1:0] rd_zero;
    logic [READ_PORTS-1:0] snoop_hit;

    logic                  alloc_zero;

    for (genvar p = 0; p < WRITE_PORTS; p++) begin : g_wb
        assign wb_addr_a[p] = wb_addr[p*AW +: AW];
        assign wb_data_a[p] = wb_data[p*DATA_WIDTH +: DATA_WIDTH];
        assign wb_zero[p]   = ZERO_REG && (wb_addr_a[p] == '0);
    end

    assign alloc_zero = ZERO_REG && (alloc_addr == '0);

    for (genvar i = 0; i < READ_PORTS; i++) begin : g_rd
        assign rd_addr_a[i] = rd_addr[i*AW +: AW];
        assign rd_grp[i]    = group_q[rd_addr_a[i]];
        assign rd_bank[i]   = bank_q[rd_grp[i]][rd_addr_a[i]];
        assign rd_zero[i]   = ZERO_REG && (rd_addr_a[i] == '0);
        // Out-of-range group codes (non power-of-two port counts) never match a port.
        assign rd_hit[i]    = (32'(rd_grp[i]) < WRITE_PORTS) && wb_valid[rd_grp[i]] &&
                              (wb_addr_a[rd_grp[i]] == rd_addr_a[i]);
        assign snoop_hit[i] = (32'(held_group_q[i]) < WRITE_PORTS) &&
                              wb_valid[held_group_q[i]] &&
                              (wb_addr_a[held_group_q[i]] == held_addr_q[i]);
        assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] = rd_data_q[i];
    end

    assign rd_pending = rd_pending_q;
    assign init_done  = (state_q == StRun);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bank_d       = bank_q;
        inflight_d   = inflight_q;
        group_d      = group_q;
        rd_data_d    = rd_data_q;
        rd_pending_d = rd_pending_q;
        held_addr_d  = held_addr_q;
        held_group_d = held_group_q;

        case (state_q)
            StInit: begin
                for (int p = 0; p < WRITE_PORTS; p++) begin
                    bank_d[p][cnt_q] = '0;
                end
                inflight_d[cnt_q] = 1'b0;
                group_d[cnt_q]    = '0;
                cnt_d             = cnt_q + AW'(1);
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                for (int p = 0; p < WRITE_PORTS; p++) begin
                    if (wb_valid[p] && !wb_zero[p]) begin
                        bank_d[p][wb_addr_a[p]] = wb_data_a[p];
                        inflight_d[wb_addr_a[p]] = 1'b0;
                    end
                end
                // Applied after write-back so a same-cycle alloc leaves the entry inflight.
                if (alloc_valid && !alloc_zero) begin
                    inflight_d[alloc_addr] = 1'b1;
                    group_d[alloc_addr]    = alloc_group;
                end

                if (init_req) begin
                    state_d      = StInit;
                    cnt_d        = '0;
                    rd_pending_d = '0;
                end else begin
                    for (int i = 0; i < READ_PORTS; i++) begin
                        if (rd_req) begin
                            held_addr_d[i]  = rd_addr_a[i];
                            held_group_d[i] = rd_grp[i];
                            if (rd_zero[i]) begin
                                rd_data_d[i]    = '0;
                                rd_pending_d[i] = 1'b0;
                            end else if (inflight_q[rd_addr_a[i]] && rd_hit[i]) begin
                                rd_data_d[i]    = wb_data_a[rd_grp[i]];
                                rd_pending_d[i] = 1'b0;
                            end else begin
                                rd_data_d[i]    = rd_bank[i];
                                rd_pending_d[i] = inflight_q[rd_addr_a[i]];
                            end
                        end else if (rd_pending_q[i] && snoop_hit[i]) begin
                            rd_data_d[i]    = wb_data_a[held_group_q[i]];
                            rd_pending_d[i] = 1'b0;
                        end
                    end
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StInit;
            cnt_q        <= '0;
            rd_pending_q <= '0;
            for (int i = 0; i < READ_PORTS; i++) begin
                rd_data_q[i]    <= '0;
                held_addr_q[i]  <= '0;
                held_group_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rd_pending_q <= rd_pending_d;
            rd_data_q    <= rd_data_d;
            held_addr_q  <= held_addr_d;
            held_group_q <= held_group_d;
        end
    end

    // Storage is not reset directly; the init sweep clears it after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_q     <= bank_d;
            inflight_q <= inflight_d;
            group_q    <= group_d;
        end
    end

endmodule
